// File: rtl/rotate_feed_ctrl.sv
// rotate_feed_ctrl: sequences words into a downstream right-rotate register.
// Incoming {data, cnt} words are held in a 2-entry queue. Each word is sent
// downstream as one load cycle followed by exactly cnt enable cycles.
// exp_q is a shadow of what a correct downstream register should hold.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready is combinational (!full, forced low during reset) and does not
// depend on in_valid. Once in_valid is raised, the upstream source holds
// in_data/in_cnt stable until the transfer edge.
module rotate_feed_ctrl #(
    parameter int DW = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          async_rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [CW-1:0] in_cnt,
    output logic          rot_load,
    output logic          rot_en,
    output logic [DW-1:0] rot_data,
    output logic [DW-1:0] exp_q,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ROTATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] step_q, step_d;
    logic [DW-1:0] rot_data_q, rot_data_d;
    logic [DW-1:0] shadow_q, shadow_d;
    logic          rot_load_q, rot_en_q, busy_q, done_q;

    // Queue storage and pointers.
    logic [DW-1:0] data_mem_q [2];
    logic [CW-1:0] cnt_mem_q  [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    count_q;
    logic          full, empty, push, pop;

    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign in_ready = !full && !async_rst;
    assign push     = in_valid && in_ready;

    assign rot_load    = rot_load_q;
    assign rot_en      = rot_en_q;
    assign rot_data    = rot_data_q;
    assign exp_q       = shadow_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign state_dbg_o = state_q;

    // Next-state, pop decision and datapath updates.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        rot_data_d = rot_data_q;
        shadow_d   = shadow_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shadow_d = rot_data_q;
                state_d  = (step_q != '0) ? ROTATE : DONE;
            end
            ROTATE: begin
                shadow_d = {shadow_q[0], shadow_q[DW-1:1]};
                step_d   = step_q - CW'(1);
                if (step_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The head word only leaves the queue here; the pushed word of the
        // same edge is never visible to this pop (no bypass).
        if (pop) begin
            rot_data_d = data_mem_q[rd_ptr_q];
            step_d     = cnt_mem_q[rd_ptr_q];
        end
    end

    // FSM state, datapath and outputs registered from the next state.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q    <= IDLE;
            step_q     <= '0;
            rot_data_q <= '0;
            shadow_q   <= '0;
            rot_load_q <= 1'b0;
            rot_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            rot_data_q <= rot_data_d;
            shadow_q   <= shadow_d;
            rot_load_q <= (state_d == LOAD);
            rot_en_q   <= (state_d == ROTATE);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
        end
    end

    // Queue write/read pointers and occupancy.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            data_mem_q[0] <= '0;
            data_mem_q[1] <= '0;
            cnt_mem_q[0]  <= '0;
            cnt_mem_q[1]  <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            if (push) begin
                data_mem_q[wr_ptr_q] <= in_data;
                cnt_mem_q[wr_ptr_q]  <= in_cnt;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_feed_ctrl.sv
// tb_rotate_feed_ctrl: directed checks of rotate_feed_ctrl with hand-computed
// expected values for handshake, load/enable sequencing and exp_q tracking.
module tb_rotate_feed_ctrl;

  logic       clk;
  logic       async_rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [2:0] in_cnt;
  logic       rot_load;
  logic       rot_en;
  logic [3:0] rot_data;
  logic [3:0] exp_q;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  int n_assert = 0;
  int n_fail = 0;
  bit found;

  rotate_feed_ctrl #(.DW(4), .CW(3)) dut (
    .clk        (clk),
    .async_rst  (async_rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_cnt     (in_cnt),
    .rot_load   (rot_load),
    .rot_en     (rot_en),
    .rot_data   (rot_data),
    .exp_q      (exp_q),
    .busy       (busy),
    .done       (done),
    .state_dbg_o(state_dbg)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver / checker tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_o(input string tag, input logic ld, input logic en,
                       input logic dn, input logic bz, input logic [3:0] ex);
    chk({tag, "_load"}, {7'd0, rot_load}, {7'd0, ld});
    chk({tag, "_en"},   {7'd0, rot_en},   {7'd0, en});
    chk({tag, "_done"}, {7'd0, done},     {7'd0, dn});
    chk({tag, "_busy"}, {7'd0, busy},     {7'd0, bz});
    chk({tag, "_expq"}, {4'd0, exp_q},    {4'd0, ex});
  endtask

  task automatic push_one(input logic [3:0] d, input logic [2:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_cnt   = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // directed stimulus
  initial begin
    async_rst = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_cnt    = 3'd0;

    // Reset state
    #1;
    chk_o("rst", 0, 0, 0, 0, 4'b0000);
    chk("rst_ready", {7'd0, in_ready}, 8'd0);
    chk("rst_data", {4'd0, rot_data}, 8'd0);
    tick();
    tick();
    async_rst = 1'b0;
    #1;
    chk("rel_ready", {7'd0, in_ready}, 8'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_o("idle", 0, 0, 0, 0, 4'b0000);
      chk("idle_state", {6'd0, state_dbg}, 8'd0);
    end

    // Single word 1001, cnt=1
    push_one(4'b1001, 3'd1);
    chk_o("s1_e0", 0, 0, 0, 0, 4'b0000);
    chk("s1_e0_ready", {7'd0, in_ready}, 8'd1);
    tick();
    chk_o("s1_load", 1, 0, 0, 1, 4'b0000);
    chk("s1_rdata", {4'd0, rot_data}, 8'b1001);
    tick();
    chk_o("s1_rot", 0, 1, 0, 1, 4'b1001);
    tick();
    chk_o("s1_done", 0, 0, 1, 1, 4'b1100);
    tick();
    chk_o("s1_idle", 0, 0, 0, 0, 4'b1100);

    // cnt=0 word 0110
    push_one(4'b0110, 3'd0);
    chk_o("c0_e0", 0, 0, 0, 0, 4'b1100);
    tick();
    chk_o("c0_load", 1, 0, 0, 1, 4'b1100);
    chk("c0_rdata", {4'd0, rot_data}, 8'b0110);
    tick();
    chk_o("c0_done", 0, 0, 1, 1, 4'b0110);
    tick();
    chk_o("c0_idle", 0, 0, 0, 0, 4'b0110);

    // Full rotation 1011, cnt=4
    push_one(4'b1011, 3'd4);
    tick();
    chk_o("c4_load", 1, 0, 0, 1, 4'b0110);
    tick();
    chk_o("c4_r1", 0, 1, 0, 1, 4'b1011);
    tick();
    chk_o("c4_r2", 0, 1, 0, 1, 4'b1101);
    tick();
    chk_o("c4_r3", 0, 1, 0, 1, 4'b1110);
    tick();
    chk_o("c4_r4", 0, 1, 0, 1, 4'b0111);
    tick();
    chk_o("c4_done", 0, 0, 1, 1, 4'b1011);
    tick();
    chk_o("c4_idle", 0, 0, 0, 0, 4'b1011);

    // cnt=5 wraps to a single step
    push_one(4'b1011, 3'd5);
    wait_done(20, found);
    chk("c5_done_seen", {7'd0, found}, 8'd1);
    chk("c5_expq", {4'd0, exp_q}, 8'b1101);
    tick();
    chk("c5_idle_busy", {7'd0, busy}, 8'd0);

    // Back-to-back with backpressure: A=0001/2, B=1000/1, C=1111/3
    in_valid = 1'b1; in_data = 4'b0001; in_cnt = 3'd2;
    tick();
    chk("bb_e0_ready", {7'd0, in_ready}, 8'd1);
    chk("bb_e0_busy", {7'd0, busy}, 8'd0);
    in_data = 4'b1000; in_cnt = 3'd1;
    tick();
    chk_o("bb_a_load", 1, 0, 0, 1, 4'b1101);
    chk("bb_a_rdata", {4'd0, rot_data}, 8'b0001);
    chk("bb_e1_ready", {7'd0, in_ready}, 8'd1);
    in_data = 4'b1111; in_cnt = 3'd3;
    tick();
    chk("bb_full_ready", {7'd0, in_ready}, 8'd0);
    chk_o("bb_a_r1", 0, 1, 0, 1, 4'b0001);
    // word D offered while full must be refused
    in_data = 4'b1010; in_cnt = 3'd0;
    tick();
    chk("bb_full_ready2", {7'd0, in_ready}, 8'd0);
    chk_o("bb_a_r2", 0, 1, 0, 1, 4'b1000);
    tick();
    chk_o("bb_a_done", 0, 0, 1, 1, 4'b0100);
    chk("bb_full_ready3", {7'd0, in_ready}, 8'd0);
    in_valid = 1'b0;
    tick();
    chk_o("bb_b_load", 1, 0, 0, 1, 4'b0100);
    chk("bb_b_rdata", {4'd0, rot_data}, 8'b1000);
    chk("bb_b_ready", {7'd0, in_ready}, 8'd1);
    tick();
    chk_o("bb_b_r1", 0, 1, 0, 1, 4'b1000);
    tick();
    chk_o("bb_b_done", 0, 0, 1, 1, 4'b0100);
    tick();
    chk_o("bb_c_load", 1, 0, 0, 1, 4'b0100);
    chk("bb_c_rdata", {4'd0, rot_data}, 8'b1111);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_o("bb_c_rot", 0, 1, 0, 1, 4'b1111);
    end
    tick();
    chk_o("bb_c_done", 0, 0, 1, 1, 4'b1111);
    tick();
    chk_o("bb_idle", 0, 0, 0, 0, 4'b1111);
    tick();
    chk_o("bb_idle2", 0, 0, 0, 0, 4'b1111);

    // Reset during the 2nd enable step of a cnt=6 word, one word queued
    in_valid = 1'b1; in_data = 4'b0011; in_cnt = 3'd6;
    tick();
    in_data = 4'b0101; in_cnt = 3'd1;
    tick();
    in_valid = 1'b0;
    chk_o("mr_load", 1, 0, 0, 1, 4'b1111);
    tick();
    chk_o("mr_r1", 0, 1, 0, 1, 4'b0011);
    tick();
    chk_o("mr_r2", 0, 1, 0, 1, 4'b1001);
    #2;
    async_rst = 1'b1;
    #1;
    chk_o("mr_rst", 0, 0, 0, 0, 4'b0000);
    chk("mr_rst_ready", {7'd0, in_ready}, 8'd0);
    chk("mr_rst_rdata", {4'd0, rot_data}, 8'd0);
    tick();
    async_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_o("mr_after", 0, 0, 0, 0, 4'b0000);
      chk("mr_after_ready", {7'd0, in_ready}, 8'd1);
    end
    push_one(4'b1100, 3'd2);
    wait_done(20, found);
    chk("mr_new_done_seen", {7'd0, found}, 8'd1);
    chk("mr_new_expq", {4'd0, exp_q}, 8'b0011);
    tick();
    chk("mr_new_idle", {7'd0, busy}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rotate_feed_ctrl.md
Name: rotate_feed_ctrl

Overview:
- Upstream sequencer for the right-rotate register stage.
- Accepts words with a per-word rotation count over a valid/ready handshake and buffers them in a 2-entry queue.
- Drives the rotate register's load/en/data inputs: one load cycle, then exactly cnt enable cycles per word.
- Keeps a shadow model (exp_q) of the downstream q for in-system checking, and pulses done when each word completes.

Parameters:
DW, 4, data width; must equal the downstream rotate register width
CW, 3, rotation-count width; per-word count range 0..2**CW-1

Ports:
clk  input  1  clock; all state updates on rising edge
async_rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  queue can accept a word
in_data  input  DW  word to load into rotate register
in_cnt  input  CW  number of right-rotate steps for this word
rot_load  output  1  drives downstream load
rot_en  output  1  drives downstream en
rot_data  output  DW  drives downstream data
exp_q  output  DW  shadow of downstream q
busy  output  1  a word is in LOAD/ROTATE/DONE
done  output  1  one-cycle pulse: word finished, exp_q final

Behaviour:
- Reset (async_rst=1, takes effect immediately, no clock needed):
  - Queue emptied; state IDLE.
  - rot_load=0, rot_en=0, rot_data=0, exp_q=0, busy=0, done=0, step counter=0.
  - in_ready=0 while async_rst is high.
  - Reset mid-operation discards the queued word and the in-flight word.
- in_ready = !full (combinational) whenever not in reset.
- Push occurs on an edge where in_valid && in_ready.
- Queue: 2-entry FIFO of {data, cnt}.
  - When full, in_ready=0. No push is accepted even on an edge that also pops.
  - No bypass: a word pushed into an empty queue is not popped on the same edge.
- rot_load, rot_en, rot_data, busy and done are registered, decoded from the next state.
- FSM states: IDLE, LOAD, ROTATE, DONE.
  - IDLE: if queue non-empty at an edge: pop, rot_data<=head.data, step counter<=head.cnt, go to LOAD. Otherwise stay.
  - LOAD: one cycle with rot_load=1, rot_en=0, busy=1.
    - At the LOAD edge: exp_q<=rot_data.
    - Go to ROTATE if cnt!=0, else go to DONE.
  - ROTATE: rot_load=0, rot_en=1, busy=1.
    - Each edge: exp_q<={exp_q[0],exp_q[DW-1:1]} and counter decrements.
    - At the edge where counter==1: go to DONE.
    - Exactly cnt enable cycles per word.
  - DONE: one cycle with done=1, busy=1, rot_en=0; exp_q holds the final value.
    - At the DONE edge: if queue non-empty, pop and go to LOAD (back-to-back). Else go to IDLE.
- rot_data holds its last loaded value outside LOAD. It changes only on a pop.
- exp_q changes only on edges where rot_load or rot_en is high. It exactly tracks a correctly working downstream register driven by these outputs.
- Latency: push edge E0 → pop at E1 (LOAD during E1..E2) → exp_q=data at E2 → exp_q final at E(2+cnt) → done high in cycle E(2+cnt)..E(3+cnt).
- Per-word occupancy is cnt+2 cycles when back-to-back.
- cnt=DW returns the original word; cnt>DW wraps modulo DW.

Test Plan:
- Reset then idle:
  - async_rst asserted mid-cycle → all outputs 0 immediately and in_ready=0.
  - After release → in_ready=1, busy=0, no rot_load/rot_en activity for 5 cycles.
- Single word, data=4'b1001, cnt=1:
  - rot_load=1 for 1 cycle, then rot_en=1 for 1 cycle.
  - exp_q sequence 1001→1100.
  - done=1 with exp_q=1100, then busy=0.
- cnt=0, data=4'b0110 → LOAD followed directly by DONE; rot_en never asserted; done with exp_q=0110.
- Full rotation, data=4'b1011, cnt=4:
  - exp_q sequence 1011,1101,1110,0111,1011.
  - done with exp_q=1011; cnt=5 ends at 1101.
- Back-to-back and backpressure:
  - Push 3 words on consecutive cycles (A=0001/cnt2, B=1000/cnt1, C=1111/cnt3) with the queue initially empty.
  - in_ready drops to 0 when 2 are queued; C is accepted only after the first pop.
  - Required exp_q at the three done pulses: 0100, 0100, 1111.
  - No idle cycle between a DONE and the next LOAD.
- Reset mid-ROTATE:
  - async_rst pulse during the 2nd enable step of a cnt=6 word with 1 word queued → outputs clear immediately.
  - After release, no further rot_load/rot_en activity until a new push; the queued word is lost.
